// File: rtl/alu_sequencer.sv
// alu_sequencer: registered request/response wrapper around a combinational
// 8-bit ALU. One request is accepted in IDLE, and its operands are held on the
// ALU for one EXEC cycle. The result and flags are captured at the end of that
// cycle and then offered downstream from DONE. A persistent flag register
// supplies the carry-in for chained multi-precision adds.
module alu_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream request
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic [3:0]            req_op_i,
  input  logic                  req_chain_i,
  // ALU side
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [3:0]            alu_op_o,
  output logic [3:0]            alu_iflags_o,
  input  logic [DATA_WIDTH-1:0] alu_y_i,
  input  logic [3:0]            alu_oflags_i,
  // downstream response
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_y_o,
  output logic [3:0]            rsp_flags_o,
  output logic                  rsp_err_o,
  output logic [3:0]            flags_o
);

  // Flag bit order is {V,N,C,Z}; only the carry position is ever rewritten.
  localparam int FLAG_C = 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
  logic [3:0]            alu_op_q;
  logic                  chain_q;
  logic                  legal_q;
  logic [DATA_WIDTH-1:0] rsp_y_q;
  logic [3:0]            rsp_flags_q;
  logic                  rsp_err_q;
  logic [3:0]            flags_q;

  logic                  req_legal;
  logic                  carry_in;
  logic                  accept;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode; both handshakes depend on state only.
  always_comb begin
    // NOTE: every output gets a default up front, so no path through the case
    // leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Reads 0 while reset is held, 1 as soon as it is released.
        req_ready_o = !rst;
        if (req_valid_i) state_d = EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Classify the incoming opcode so EXEC only has to consult one bit.
  always_comb begin
    req_legal = 1'b0;
    unique case (req_op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: req_legal = 1'b1;
      default:                               req_legal = 1'b0;
    endcase
  end

  assign accept   = (state_q == IDLE) && req_valid_i;
  // The stored carry feeds only a chained Add; Sub and logic ops always see 0.
  assign carry_in = chain_q && (alu_op_q == OP_ADD) && flags_q[FLAG_C];

  // Operand capture in IDLE and result/flag capture at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      chain_q     <= 1'b0;
      legal_q     <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      flags_q     <= '0;
    end else begin
      if (accept) begin
        alu_a_q  <= req_a_i;
        alu_b_q  <= req_b_i;
        alu_op_q <= req_op_i;
        chain_q  <= req_chain_i;
        legal_q  <= req_legal;
      end
      if (state_q == EXEC) begin
        if (legal_q) begin
          rsp_y_q     <= alu_y_i;
          rsp_flags_q <= alu_oflags_i;
          flags_q     <= alu_oflags_i;
          rsp_err_q   <= 1'b0;
        end else begin
          // The ALU drives X for unknown opcodes, so none of it is sampled.
          rsp_y_q     <= '0;
          rsp_flags_q <= flags_q;
          rsp_err_q   <= 1'b1;
        end
      end
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign alu_iflags_o = {flags_q[3:2], carry_in, flags_q[0]};
  assign rsp_y_o      = rsp_y_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign rsp_err_o    = rsp_err_q;
  assign flags_o      = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU on the ALU port, scoreboard of
// expected responses filled when a request is accepted, and one task per
// scenario comparing DUT outputs against the scoreboard and known values.
module tb_alu_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0110;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_chain;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_op, alu_iflags, alu_oflags;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_y;
  logic [3:0] rsp_flags, flags;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .req_chain_i  (req_chain),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_iflags_o (alu_iflags),
    .alu_y_i      (alu_y),
    .alu_oflags_i (alu_oflags),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_y_o      (rsp_y),
    .rsp_flags_o  (rsp_flags),
    .rsp_err_o    (rsp_err),
    .flags_o      (flags)
  );

  // Reference ALU: returns {flags, y}, flags ordered {V,N,C,Z}.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input logic cin);
    logic [8:0] wide;
    logic [7:0] y;
    logic       v, c;
    wide = 9'd0; y = 8'd0; v = 1'b0; c = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        y = wide[7:0]; c = wide[8];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      OP_SUB: begin
        wide = {1'b0, a} + {1'b0, ~b} + 9'd1;
        y = wide[7:0]; c = wide[8];
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: y = 8'd0;
    endcase
    return {v, y[7], c, (y == 8'd0), y};
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR) || (op == OP_XOR);
  endfunction

  // Behavioural ALU attached to the DUT; unknown opcodes produce X.
  always_comb begin
    logic [11:0] r;
    r = ref_alu(alu_a, alu_b, alu_op, alu_iflags[1]);
    if (is_legal(alu_op)) begin
      alu_y      = r[7:0];
      alu_oflags = r[11:8];
    end else begin
      alu_y      = 'x;
      alu_oflags = 'x;
    end
  end

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] f;
    logic       err;
  } rsp_t;

  rsp_t       sb_q[$];
  rsp_t       exp_r;
  logic [3:0] m_flags;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] obs_y;
  logic [3:0] obs_f, obs_flags;
  logic       obs_err;
  int         obs_wait;

  // Predict the response of an accepted request and update the model flags.
  task automatic push_expected(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] op, input logic chain);
    logic [11:0] r;
    rsp_t        e;
    if (is_legal(op)) begin
      r = ref_alu(a, b, op, (op == OP_ADD && chain) ? m_flags[1] : 1'b0);
      m_flags = r[11:8];
      e = '{y: r[7:0], f: r[11:8], err: 1'b0};
    end else begin
      e = '{y: 8'd0, f: m_flags, err: 1'b1};
    end
    sb_q.push_back(e);
  endtask

  // Issue one request from IDLE; returns at the falling edge inside EXEC.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] op, input logic chain);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL send_ready_timeout: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
    req_a = a; req_b = b; req_op = op; req_chain = chain; req_valid = 1'b1;
    @(posedge clk);
    push_expected(a, b, op, chain);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, capture it, pop the prediction, consume it.
  task automatic recv();
    obs_wait = 0;
    while (!rsp_valid && obs_wait < 10) begin
      @(negedge clk);
      obs_wait++;
    end
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL recv_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, obs_wait);
    end
    obs_y = rsp_y; obs_f = rsp_flags; obs_err = rsp_err; obs_flags = flags;
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 8'd0; req_b = 8'd0; req_op = 4'd0; req_chain = 1'b0;
    m_flags = 4'd0;
    #1;
    n_checks++;
    if ({alu_a, alu_b, alu_op, rsp_y, rsp_flags, flags, rsp_valid, rsp_err, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%h b=%h op=%h y=%h rf=%b f=%b v=%b e=%b rdy=%b, want all 0",
               alu_a, alu_b, alu_op, rsp_y, rsp_flags, flags, rsp_valid, rsp_err, req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
    end
  endtask

  task automatic test_add_latency();
    send(8'h7F, 8'h01, OP_ADD, 1'b0);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_handshake: rsp_valid=%b req_ready=%b, want 0 0", rsp_valid, req_ready);
    end
    recv();
    n_checks++;
    if (obs_wait !== 1) begin
      n_fail++;
      $display("FAIL add_latency: response after %0d extra cycles, want 1", obs_wait);
    end
    n_checks++;
    if ({obs_y, obs_f, obs_err} !== {exp_r.y, exp_r.f, exp_r.err} || obs_y !== 8'h80 ||
        obs_f !== 4'b1100 || obs_flags !== 4'b1100 || obs_flags !== m_flags) begin
      n_fail++;
      $display("FAIL add_7f_01: y=%h rf=%b err=%b flags=%b, want y=80 rf=1100 err=0 flags=1100",
               obs_y, obs_f, obs_err, obs_flags);
    end
  endtask

  task automatic test_sub();
    send(8'h05, 8'h05, OP_SUB, 1'b1);
    recv();
    n_checks++;
    if ({obs_y, obs_f, obs_err} !== {exp_r.y, exp_r.f, exp_r.err} || obs_y !== 8'h00 ||
        obs_f !== 4'b0011 || obs_flags !== m_flags) begin
      n_fail++;
      $display("FAIL sub_05_05: y=%h rf=%b err=%b flags=%b, want y=00 rf=0011 err=0 flags=0011",
               obs_y, obs_f, obs_err, obs_flags);
    end
  endtask

  task automatic test_chain();
    logic [1:0] cfg;
    for (int pass = 0; pass < 2; pass++) begin
      send(8'hFF, 8'h01, OP_ADD, 1'b0);
      recv();
      n_checks++;
      if ({obs_y, obs_f} !== {exp_r.y, exp_r.f} || obs_f !== 4'b0011 || obs_flags !== 4'b0011) begin
        n_fail++;
        $display("FAIL chain_low_%0d: y=%h rf=%b flags=%b, want y=00 rf=0011 flags=0011",
                 pass, obs_y, obs_f, obs_flags);
      end
      send(8'h00, 8'h00, OP_ADD, (pass == 0));
      cfg = {alu_iflags[1], 1'b0};
      n_checks++;
      if (cfg[1] !== (pass == 0)) begin
        n_fail++;
        $display("FAIL chain_cin_%0d: alu_iflags[1]=%b, want %b", pass, cfg[1], (pass == 0));
      end
      recv();
      n_checks++;
      if ({obs_y, obs_f, obs_err} !== {exp_r.y, exp_r.f, exp_r.err} ||
          obs_y !== ((pass == 0) ? 8'h01 : 8'h00) || obs_flags !== m_flags) begin
        n_fail++;
        $display("FAIL chain_high_%0d: y=%h rf=%b flags=%b, want y=%h rf=%b",
                 pass, obs_y, obs_f, obs_flags, exp_r.y, exp_r.f);
      end
    end
  endtask

  task automatic test_illegal();
    send(8'h7F, 8'h01, OP_ADD, 1'b0);
    recv();
    send(8'h12, 8'h34, 4'b0010, 1'b1);
    recv();
    n_checks++;
    if ({obs_y, obs_f, obs_err} !== {exp_r.y, exp_r.f, exp_r.err} || obs_err !== 1'b1 ||
        obs_y !== 8'h00 || obs_f !== 4'b1100 || obs_flags !== 4'b1100) begin
      n_fail++;
      $display("FAIL illegal_op: y=%h rf=%b err=%b flags=%b, want y=00 rf=1100 err=1 flags=1100",
               obs_y, obs_f, obs_err, obs_flags);
    end
    send(8'hF0, 8'h3C, OP_AND, 1'b0);
    recv();
    n_checks++;
    if ({obs_y, obs_f, obs_err} !== {exp_r.y, exp_r.f, exp_r.err} || obs_y !== 8'h30 ||
        obs_err !== 1'b0 || obs_f !== 4'b0000 || obs_flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL and_after_illegal: y=%h rf=%b err=%b flags=%b, want y=30 rf=0000 err=0 flags=0000",
               obs_y, obs_f, obs_err, obs_flags);
    end
  endtask

  task automatic test_backpressure();
    send(8'h81, 8'h81, OP_ADD, 1'b0);
    @(negedge clk);
    exp_r = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_a = 8'(i * 37 + 5); req_b = 8'h22; req_op = OP_XOR; req_chain = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_y !== exp_r.y ||
          rsp_flags !== exp_r.f || rsp_err !== 1'b0 || alu_a !== 8'h81) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: v=%b rdy=%b y=%h rf=%b err=%b alu_a=%h, want 1 0 %h %b 0 81",
                 i, rsp_valid, req_ready, rsp_y, rsp_flags, rsp_err, alu_a, exp_r.y, exp_r.f);
      end
    end
    void'(sb_q.pop_front());
    rsp_ready = 1'b1;
    req_a = 8'h11; req_b = 8'h22; req_op = OP_OR; req_chain = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: req_ready=%b rsp_valid=%b, want 1 0", req_ready, rsp_valid);
    end
    rsp_ready = 1'b0;
    @(posedge clk);
    push_expected(8'h11, 8'h22, OP_OR, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    recv();
    n_checks++;
    if ({obs_y, obs_f, obs_err} !== {exp_r.y, exp_r.f, exp_r.err} || obs_y !== 8'h33) begin
      n_fail++;
      $display("FAIL backpressure_next: y=%h rf=%b err=%b, want y=33 rf=%b err=0", obs_y, obs_f, obs_err, exp_r.f);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rsp_ready = 1'b1;
    req_a = 8'hFF; req_b = 8'h01; req_op = OP_ADD; req_chain = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    push_expected(8'hFF, 8'h01, OP_ADD, 1'b0);
    @(negedge clk);
    req_a = 8'h00; req_b = 8'h00; req_chain = 1'b1;
    @(negedge clk);
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== exp_r.y || rsp_flags !== exp_r.f) begin
      n_fail++;
      $display("FAIL b2b_first: v=%b y=%h rf=%b, want 1 %h %b", rsp_valid, rsp_y, rsp_flags, exp_r.y, exp_r.f);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: req_ready=%b rsp_valid=%b, want 1 0", req_ready, rsp_valid);
    end
    @(posedge clk);
    push_expected(8'h00, 8'h00, OP_ADD, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (alu_iflags[1] !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_cin: alu_iflags[1]=%b rsp_valid=%b, want 1 0", alu_iflags[1], rsp_valid);
    end
    @(negedge clk);
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== exp_r.y || rsp_flags !== exp_r.f || rsp_y !== 8'h01) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b y=%h rf=%b, want 1 01 %b", rsp_valid, rsp_y, rsp_flags, exp_r.f);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    send(8'h80, 8'h80, OP_ADD, 1'b0);
    recv();
    n_checks++;
    if (obs_flags !== 4'b1011 || obs_flags !== m_flags) begin
      n_fail++;
      $display("FAIL pre_reset_flags: flags=%b, want 1011", obs_flags);
    end
    send(8'h10, 8'h20, OP_ADD, 1'b0);
    rst = 1'b1;
    void'(sb_q.pop_back());
    m_flags = 4'd0;
    #1;
    n_checks++;
    if ({alu_a, alu_b, alu_op, rsp_y, rsp_flags, flags, rsp_valid, rsp_err, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: a=%h b=%h op=%h y=%h rf=%b f=%b v=%b e=%b rdy=%b, want all 0",
               alu_a, alu_b, alu_op, rsp_y, rsp_flags, flags, rsp_valid, rsp_err, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_ready: req_ready=%b, want 1", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_no_rsp_%0d: rsp_valid=%b, want 0", i, rsp_valid);
      end
    end
    send(8'h01, 8'h01, OP_ADD, 1'b0);
    recv();
    n_checks++;
    if ({obs_y, obs_f, obs_err} !== {exp_r.y, exp_r.f, exp_r.err} || obs_y !== 8'h02) begin
      n_fail++;
      $display("FAIL post_reset_add: y=%h rf=%b err=%b, want y=02 rf=%b err=0", obs_y, obs_f, obs_err, exp_r.f);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_latency();
    test_sub();
    test_chain();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
